bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the single external APB-style bus between `NUM_MASTERS` bus masters, such as the core's cache-fill bus access unit, a debug/loader port and a DMA engine. Each master presents a request phase on its own port. The arbiter grants one master at a time using round-robin, then runs its own setup/access sequence on the shared bus. Each access is bounded by a timeout watchdog, so a non-responding slave cannot hang the core.

## Interface
- `NUM_MASTERS`, 2: number of masters; must be ≥ 2.
- `TIMEOUT`, 255: maximum Access-phase cycles before a forced error completion; 0 disables the watchdog.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `m_select`  in  NUM_MASTERS  per-master request; held high until that master's `m_ready` pulse.
- `m_write`  in  NUM_MASTERS  per-master write flag.
- `m_addr`  in  NUM_MASTERS×32  per-master byte address, packed with master i at bits [32i+31:32i].
- `m_wdata`  in  NUM_MASTERS×32  per-master write data, packed the same way.
- `m_ready`  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- `m_error`  out  NUM_MASTERS  high together with `m_ready` when the transfer timed out.
- `m_rdata`  out  32  read data, broadcast to all masters; valid only with `m_ready`.
- `grant`  out  NUM_MASTERS  one-hot owner of the bus; all zero when no master owns it.
- `s_addr`, `s_wdata`  out  32 each  shared-bus address and write data.
- `s_select`, `s_enable`, `s_write`  out  1 each  shared-bus control.
- `s_rdata`  in  32  shared-bus read data.
- `s_ready`  in  1  shared-bus completion.

## Operation
- The FSM has three states: Idle, Setup and Access. Registers: state, `grant`, round-robin pointer `last`, watchdog counter.
- **Idle:**
  - `grant` is 0, and `s_select` and `s_enable` are 0.
  - If any `m_select` bit is high, the winner is the first requesting index found by searching `last+1`, `last+2`, … modulo `NUM_MASTERS`.
  - At the clock edge the arbiter registers the winner into `grant` and moves to Setup.
- **Setup:**
  - `s_select`=1 and `s_enable`=0.
  - `s_addr`, `s_wdata` and `s_write` are muxed combinationally from the granted master.
  - Next state is always Access.
- **Access:**
  - `s_select`=1 and `s_enable`=1. `s_write` follows the granted master's `m_write`.
  - The watchdog counter increments every Access cycle.
  - **Normal completion:** when `s_ready`=1, the arbiter asserts `m_ready[g]`=1 and sets `m_rdata`=`s_rdata`. Next state is Idle, `last` becomes g, and `grant` clears to 0.
  - **Timeout:** when the counter reaches `TIMEOUT` with `s_ready`=0, the arbiter asserts `m_ready[g]`=1, `m_error[g]`=1 and `m_rdata`=0. Next state is Idle and `last` becomes g.
- `m_enable` is not an input; the arbiter alone generates the enable phase.
- `m_rdata` is 0 whenever no completion is in progress.
- `m_ready` and `m_error` for non-granted masters are always 0.
- Each completion is followed by one mandatory Idle cycle, so `s_select` is low for at least 1 cycle between transfers.
- **Granted master drops `m_select` during Setup or Access:** the arbiter still completes the transfer on the slave bus. It discards the response (`m_ready` and `m_error` stay 0) and updates `last` normally. `s_addr`, `s_wdata` and `s_write` stay latched to the values they had on entry to Setup.
- `s_addr`, `s_wdata` and `s_write` are 0 in Idle.
- The watchdog counter clears on entry to Setup. It is `$clog2(TIMEOUT+1)` bits wide and saturates rather than wraps.

## Timing
- Reset values: state=Idle, `grant`=0, `last`=`NUM_MASTERS`-1 (so master 0 wins first), counter=0. All outputs are 0.
- Asserting `rst` mid-transfer drops `s_select`/`s_enable` asynchronously. No `m_ready` is issued for the aborted transfer.
- Latency, with the request sampled in Idle at cycle t:
  - Setup at t+1.
  - Access at t+2.
  - With zero wait states, `m_ready` in cycle t+2 and Idle at t+3.
  - Minimum transfer is 3 cycles, including the Idle gap.
- Each wait state adds 1 cycle.
- Timeout fires in the `TIMEOUT`-th Access cycle, so `m_ready`/`m_error` appear at t+1+`TIMEOUT`.
- Simultaneous requests are resolved by the round-robin pointer only. A request arriving during Setup or Access waits; it is evaluated in the next Idle cycle.
- `s_ready` outside Access is ignored.

## Test plan
- **Single master, zero wait:** reset; master 0 requests a read of 0x8000_0010; the slave returns 0x1234_5678 with `s_ready` in its first Access cycle. Required: `s_select` high at t+1, `s_enable` high at t+2, `m_ready[0]` pulses at t+2 with `m_rdata`=0x1234_5678, `grant` returns to 0 at t+3.
- **Round-robin fairness:** masters 0 and 1 both hold requests continuously for 6 transfers. Required: grant order 0,1,0,1,0,1 with one Idle cycle between transfers.
- **Write with waits:** master 1 writes 0xCAFE_F00D to 0x4000_0000; the slave inserts 3 wait states. Required: `s_write`=1 and `s_wdata`=0xCAFE_F00D held for 4 Access cycles; `m_ready[1]` pulses in the 4th.
- **Timeout:** with `TIMEOUT`=4, the slave never asserts `s_ready`. Required: `m_ready[0]`=`m_error[0]`=1 and `m_rdata`=0 at t+5, then Idle at t+6.
- **Abandoned request:** master 0 drops `m_select` during Setup. Required: the slave transfer completes and `m_ready[0]` stays 0. A pending master 1 is granted next.
- **Reset mid-Access:** assert `rst`=0 during Access. Required: `s_select`, `s_enable` and `grant` go to 0 without waiting for a clock edge. After release, master 0 has priority.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one APB-style bus between NUM_MASTERS masters.
// Runs the setup/access phases itself; a watchdog bounds every access.
//
// state     | meaning
// ST_IDLE   | bus free, picking the next owner by round-robin
// ST_SETUP  | s_select high, address phase for the granted master
// ST_ACCESS | s_enable high, waiting for s_ready or the watchdog
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_select,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [NUM_MASTERS-1:0]    m_error,
    output logic [31:0]               m_rdata,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic                      s_select,
    output logic                      s_enable,
    output logic                      s_write,
    input  logic [31:0]               s_rdata,
    input  logic                      s_ready
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] rr_cand;
    logic             win_found;
    logic [CNT_W-1:0] wd_cnt;
    logic             abandon;
    logic [31:0]      held_addr;
    logic [31:0]      held_wdata;
    logic             held_write;

    logic             in_xfer;
    logic             dropped;
    logic             timeout_hit;
    logic             done_ok;
    logic             done_to;
    logic             done;
    logic             deliver;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_cand   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            rr_cand = IDX_W'((int'(last) + k) % NUM_MASTERS);
            if (!win_found && m_select[rr_cand]) begin
                win_found = 1'b1;
                win_idx   = rr_cand;
            end
        end
    end

    assign in_xfer     = (state == ST_SETUP) || (state == ST_ACCESS);
    // Once the owner lets go of m_select the transfer still finishes, silently.
    assign dropped     = abandon || !m_select[gnt_idx];
    assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == CNT_LAST);
    assign done_ok     = (state == ST_ACCESS) && s_ready;
    assign done_to     = (state == ST_ACCESS) && !s_ready && timeout_hit;
    assign done        = done_ok || done_to;
    assign deliver     = done && !dropped;

    assign m_ready  = deliver ? grant : '0;
    assign m_error  = (deliver && done_to) ? grant : '0;
    assign m_rdata  = (deliver && done_ok) ? s_rdata : 32'd0;
    assign s_select = in_xfer;
    assign s_enable = (state == ST_ACCESS);

    always_comb begin
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_write = 1'b0;
        if (in_xfer) begin
            if (dropped) begin
                s_addr  = held_addr;
                s_wdata = held_wdata;
                s_write = held_write;
            end else begin
                s_addr  = m_addr[{gnt_idx, 5'd0} +: 32];
                s_wdata = m_wdata[{gnt_idx, 5'd0} +: 32];
                s_write = m_write[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            gnt_idx    <= '0;
            last       <= IDX_LAST;
            wd_cnt     <= '0;
            abandon    <= 1'b0;
            held_addr  <= 32'd0;
            held_wdata <= 32'd0;
            held_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state      <= ST_SETUP;
                        grant      <= NUM_MASTERS'(1) << win_idx;
                        gnt_idx    <= win_idx;
                        wd_cnt     <= '0;
                        abandon    <= 1'b0;
                        held_addr  <= m_addr[{win_idx, 5'd0} +: 32];
                        held_wdata <= m_wdata[{win_idx, 5'd0} +: 32];
                        held_write <= m_write[win_idx];
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                    if (!m_select[gnt_idx]) abandon <= 1'b1;
                end
                ST_ACCESS: begin
                    if (!m_select[gnt_idx]) abandon <= 1'b1;
                    if (wd_cnt != '1) wd_cnt <= wd_cnt + CNT_W'(1);
                    if (done) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        last  <= gnt_idx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a transfer-level model.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;
    localparam logic [31:0] A0 = 32'h8000_0010;
    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] A1 = 32'h4000_0000;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;

    logic        clk;
    logic        rst;
    logic [1:0]  m_select;
    logic [1:0]  m_write;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ready;
    logic [1:0]  m_error;
    logic [31:0] m_rdata;
    logic [1:0]  grant;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_select;
    logic        s_enable;
    logic        s_write;
    logic [31:0] s_rdata;
    logic        s_ready;

    bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_select(m_select), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_error(m_error), .m_rdata(m_rdata), .grant(grant),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_select(s_select), .s_enable(s_enable),
        .s_write(s_write), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  wr;
        logic        s_rdy;
        logic [31:0] s_rd;
        logic [1:0]  e_grant;
        logic        e_ssel;
        logic        e_sen;
        logic        e_swr;
        logic [31:0] e_saddr;
        logic [31:0] e_swdata;
        logic [1:0]  e_rdy;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[18];
    int checks = 0;
    int errors = 0;

    function automatic logic [104:0] mk(logic [1:0] g, logic ss, logic se, logic sw,
                                        logic [31:0] sa, logic [31:0] sd,
                                        logic [1:0] r, logic [1:0] e, logic [31:0] rd);
        return {g, ss, se, sw, sa, sd, r, e, rd};
    endfunction

    function automatic logic [104:0] out_vec();
        return {grant, s_select, s_enable, s_write, s_addr, s_wdata, m_ready, m_error, m_rdata};
    endfunction

    task automatic check(input string name, input logic [104:0] got, input logic [104:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b0;
        m_select = 2'b00;
        m_write  = 2'b00;
        m_addr   = {A1, A0};
        m_wdata  = {D1, D0};
        s_ready  = 1'b0;
        s_rdata  = 32'd0;
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    // Transfer-level reference model state
    int          own;
    int          age;
    int          rr_last;
    int          own_before;
    logic        drp;
    logic [31:0] lat_a;
    logic [31:0] lat_d;
    logic        lat_w;
    logic [1:0]  g_req;
    logic [1:0]  g_wr;
    logic [31:0] g_addr[2];
    logic [31:0] g_wdata[2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'b01, 2'b00, 1'b0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};
        tbl[1]  = '{2'b01, 2'b00, 1'b0, 32'h0,         2'b01, 1, 0, 0, A0,    D0,    2'b00, 2'b00, 32'h0};
        tbl[2]  = '{2'b01, 2'b00, 1'b1, 32'h1234_5678, 2'b01, 1, 1, 0, A0,    D0,    2'b01, 2'b00, 32'h1234_5678};
        tbl[3]  = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};
        tbl[4]  = '{2'b10, 2'b10, 1'b0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};
        tbl[5]  = '{2'b10, 2'b10, 1'b0, 32'h0,         2'b10, 1, 0, 1, A1,    D1,    2'b00, 2'b00, 32'h0};
        tbl[6]  = '{2'b10, 2'b10, 1'b0, 32'h0,         2'b10, 1, 1, 1, A1,    D1,    2'b00, 2'b00, 32'h0};
        tbl[7]  = '{2'b10, 2'b10, 1'b0, 32'h0,         2'b10, 1, 1, 1, A1,    D1,    2'b00, 2'b00, 32'h0};
        tbl[8]  = '{2'b10, 2'b10, 1'b0, 32'h0,         2'b10, 1, 1, 1, A1,    D1,    2'b00, 2'b00, 32'h0};
        tbl[9]  = '{2'b10, 2'b10, 1'b1, 32'hDEAD_BEEF, 2'b10, 1, 1, 1, A1,    D1,    2'b10, 2'b00, 32'hDEAD_BEEF};
        tbl[10] = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};
        tbl[11] = '{2'b01, 2'b00, 1'b1, 32'h5555_5555, 2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};
        tbl[12] = '{2'b01, 2'b00, 1'b1, 32'h5555_5555, 2'b01, 1, 0, 0, A0,    D0,    2'b00, 2'b00, 32'h0};
        tbl[13] = '{2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF, 2'b01, 1, 1, 0, A0,    D0,    2'b00, 2'b00, 32'h0};
        tbl[14] = '{2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF, 2'b01, 1, 1, 0, A0,    D0,    2'b00, 2'b00, 32'h0};
        tbl[15] = '{2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF, 2'b01, 1, 1, 0, A0,    D0,    2'b00, 2'b00, 32'h0};
        tbl[16] = '{2'b01, 2'b00, 1'b0, 32'hFFFF_FFFF, 2'b01, 1, 1, 0, A0,    D0,    2'b01, 2'b01, 32'h0};
        tbl[17] = '{2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0};

        rst      = 1'b0;
        m_select = 2'b00;
        m_write  = 2'b00;
        m_addr   = {A1, A0};
        m_wdata  = {D1, D0};
        s_ready  = 1'b0;
        s_rdata  = 32'd0;
        #2;
        check("reset_outputs", out_vec(), 105'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;

        // Zero-wait read, write with 3 waits, timeout after TO access cycles
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            m_select = tbl[i].sel;
            m_write  = tbl[i].wr;
            s_ready  = tbl[i].s_rdy;
            s_rdata  = tbl[i].s_rd;
            #1;
            check($sformatf("vec%0d", i), out_vec(),
                  mk(tbl[i].e_grant, tbl[i].e_ssel, tbl[i].e_sen, tbl[i].e_swr,
                     tbl[i].e_saddr, tbl[i].e_swdata, tbl[i].e_rdy, tbl[i].e_err, tbl[i].e_rdata));
        end

        // Round-robin fairness with both masters requesting continuously
        do_reset();
        for (int c = 0; c < 18; c++) begin
            logic [1:0] eg;
            next_cycle();
            m_select = 2'b11;
            s_ready  = 1'b1;
            s_rdata  = 32'(c);
            #1;
            eg = ((c % 3) == 0) ? 2'b00 : (((c / 3) % 2) == 0 ? 2'b01 : 2'b10);
            check($sformatf("fair%0d", c), 105'({grant, s_select, m_ready}),
                  105'({eg, eg != 2'b00, ((c % 3) == 2) ? eg : 2'b00}));
        end

        // Abandoned request: master 0 drops during Setup, master 1 waits
        do_reset();
        next_cycle(); m_select = 2'b11; #1;
        check("abandon_idle", out_vec(), 105'd0);
        next_cycle(); m_select = 2'b10; #1;
        check("abandon_setup", out_vec(), mk(2'b01, 1, 0, 0, A0, D0, 2'b00, 2'b00, 32'h0));
        next_cycle(); m_addr[31:0] = 32'h0BAD_0BAD; s_ready = 1'b1; s_rdata = 32'h77; #1;
        check("abandon_access", out_vec(), mk(2'b01, 1, 1, 0, A0, D0, 2'b00, 2'b00, 32'h0));
        next_cycle(); s_ready = 1'b0; #1;
        check("abandon_gap", out_vec(), 105'd0);
        next_cycle(); #1;
        check("abandon_next_setup", out_vec(), mk(2'b10, 1, 0, 0, A1, D1, 2'b00, 2'b00, 32'h0));
        next_cycle(); s_ready = 1'b1; s_rdata = 32'h600D; #1;
        check("abandon_next_done", out_vec(), mk(2'b10, 1, 1, 0, A1, D1, 2'b10, 2'b00, 32'h600D));
        next_cycle(); m_select = 2'b00; s_ready = 1'b0; #1;
        check("abandon_end", out_vec(), 105'd0);

        // Reset asserted in the middle of an Access phase
        do_reset();
        next_cycle(); m_select = 2'b01; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("rst_pre_access", out_vec(), mk(2'b01, 1, 1, 0, A0, D0, 2'b00, 2'b00, 32'h0));
        #1 rst = 1'b0;
        #1;
        check("rst_async_drop", out_vec(), 105'd0);
        #2 rst = 1'b1;
        m_select = 2'b11;
        #1;
        check("rst_idle_after", out_vec(), 105'd0);
        next_cycle(); #1;
        check("rst_m0_priority", out_vec(), mk(2'b01, 1, 0, 0, A0, D0, 2'b00, 2'b00, 32'h0));

        // Randomized traffic against the transfer-level model
        do_reset();
        own = -1; age = 0; rr_last = N - 1; drp = 1'b0;
        lat_a = 32'd0; lat_d = 32'd0; lat_w = 1'b0;
        g_req = 2'b00; g_wr = 2'b00;
        for (int i = 0; i < N; i++) begin
            g_addr[i]  = 32'd0;
            g_wdata[i] = 32'd0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0]  e_g, e_r, e_e;
            logic        e_ss, e_se, e_sw, dnow, fin, fin_to, dlv;
            logic [31:0] e_sa, e_sd, e_rd;
            next_cycle();
            for (int i = 0; i < N; i++) begin
                m_select[i]         = g_req[i];
                m_write[i]          = g_wr[i];
                m_addr[32*i +: 32]  = g_addr[i];
                m_wdata[32*i +: 32] = g_wdata[i];
            end
            s_ready = ($urandom_range(3) == 0);
            s_rdata = $urandom;
            #1;
            e_g = 2'b00; e_r = 2'b00; e_e = 2'b00; e_ss = 1'b0; e_se = 1'b0; e_sw = 1'b0;
            e_sa = 32'd0; e_sd = 32'd0; e_rd = 32'd0; dnow = 1'b0;
            fin = 1'b0; fin_to = 1'b0; dlv = 1'b0;
            if (own >= 0) begin
                e_g  = 2'(32'd1 << own);
                e_ss = 1'b1;
                e_se = (age >= 2);
                dnow = drp || !m_select[own];
                e_sa = dnow ? lat_a : m_addr[32*own +: 32];
                e_sd = dnow ? lat_d : m_wdata[32*own +: 32];
                e_sw = dnow ? lat_w : m_write[own];
                if (age >= 2 && s_ready) fin = 1'b1;
                else if (age >= 2 && (age - 1) == TO) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
                if (fin && !dnow) begin
                    dlv = 1'b1;
                    e_r = e_g;
                    if (fin_to) e_e = e_g;
                    else e_rd = s_rdata;
                end
            end
            check("random", out_vec(), mk(e_g, e_ss, e_se, e_sw, e_sa, e_sd, e_r, e_e, e_rd));

            own_before = own;
            if (own < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (rr_last + k) % N;
                    if (own < 0 && m_select[c]) begin
                        own   = c;
                        age   = 1;
                        drp   = 1'b0;
                        lat_a = m_addr[32*c +: 32];
                        lat_d = m_wdata[32*c +: 32];
                        lat_w = m_write[c];
                    end
                end
            end else begin
                if (!m_select[own]) drp = 1'b1;
                if (fin) begin
                    rr_last = own;
                    own     = -1;
                end else begin
                    age++;
                end
            end

            for (int i = 0; i < N; i++) begin
                if (g_req[i]) begin
                    if (dlv && own_before == i) begin
                        g_req[i] = ($urandom_range(1) == 0);
                        g_addr[i]  = $urandom;
                        g_wdata[i] = $urandom;
                        g_wr[i]    = 1'($urandom_range(1));
                    end else if (own == i && $urandom_range(15) == 0) begin
                        g_req[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    g_req[i]   = 1'b1;
                    g_addr[i]  = $urandom;
                    g_wdata[i] = $urandom;
                    g_wr[i]    = 1'($urandom_range(1));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
